lsu_bus_master: RTL and testbench
=================================

// Module: lsu_bus_master
// PURPOSE
//  Core-side initiator for the 64-bit data bus (RAM/IO/CSR decode lives in data_bus).
//  Accepts one load/store at a time from the pipeline and drives rw/addr/write on the bus.
//  Sub-dword loads are extracted and extended; sub-dword stores use read-modify-write.
//  Returns data or a fault to the pipeline. Forwards bus exceptions.
// PARAMETERS
//  RD_LATENCY  1  cycles from bus_addr valid to bus_read/bus_exception valid (>=0)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous reset, active low
//  req_valid      in   1   pipeline request present
//  req_ready      out  1   high only in IDLE; a request is accepted when valid&ready
//  req_store      in   1   1=store, 0=load
//  req_size       in   2   0=byte 1=half 2=word 3=dword
//  req_unsigned   in   1   loads: 1=zero-extend, 0=sign-extend
//  req_addr       in   64  byte address
//  req_wdata      in   64  store data; size bytes taken from bits [8*2^size-1:0]
//  rsp_valid      out  1   one-cycle completion pulse; no backpressure
//  rsp_rdata      out  64  extended load data; 0 for stores and faults
//  rsp_fault      out  1   qualified by rsp_valid: misaligned or bus exception
//  bus_rw         out  1   1=write; asserted only in WR
//  bus_addr       out  64  dword-aligned address {addr[63:3],3'b0}; 0 in IDLE
//  bus_write      out  64  write data; 0 unless in WR
//  bus_read       in   64  read data
//  bus_exception  in   1   bus error for current bus_addr
// BEHAVIOUR
//  - Reset: state=IDLE. rsp_valid=0, rsp_rdata=0, rsp_fault=0, bus_rw=0, bus_addr=0,
//    bus_write=0. req_ready=1. Every output is registered.
//  - FSM: IDLE -> RD -> (WR) -> RESP -> IDLE.
//    IDLE: latch the request on accept. Load or sub-dword store -> RD. Dword store -> WR.
//    RD: bus_rw=0 and bus_addr held for RD_LATENCY+1 cycles (down-counter).
//        bus_read and bus_exception are sampled on the last RD cycle.
//        Load -> RESP. Store with exception -> RESP with fault; WR is never entered.
//        Store without exception -> WR.
//    WR: a single cycle with bus_rw=1. bus_write = merged dword.
//        bus_exception is sampled this cycle and sets the fault. -> RESP.
//    RESP: rsp_valid=1 for exactly one cycle; req_ready=0. -> IDLE.
//  - Latency from accept cycle T, with RD_LATENCY=1:
//    load rsp at T+3; dword store at T+2; sub-dword store at T+4.
//  - Lanes are little-endian; lane offset = addr[2:0].
//    Load: bus_read >> (8*addr[2:0]), truncate to size, then extend per req_unsigned.
//    Dword loads are never extended.
//    Store merge: the size bytes at the offset are replaced by wdata; all other bytes keep bus_read.
//  - Misaligned means addr[size-1:0] != 0 (byte loads/stores are never misaligned).
//  - req_valid while req_ready=0 is ignored; the pipeline holds the request.
//  - rst_n asserted mid-operation clears state immediately. bus_rw drops asynchronously.
//    No partial write is issued and no response is produced for the killed request.
// CONFIGURATION
//  LSU_MISALIGN_FAULT_EN defined: a misaligned request goes IDLE -> RESP with rsp_fault=1.
//    No bus cycle occurs and bus_addr stays 0.
//  LSU_MISALIGN_FAULT_EN undefined: addr[size-1:0] is forced to 0 and the access proceeds.
//    Misalignment never faults.
// TESTING
//  1 load dword @0x100, bus_read=0x1122334455667788 -> rsp_rdata=0x1122334455667788,
//    fault=0, rsp at T+3, bus_rw never 1.
//  2 load byte signed @0x103, bus_read=0x00000000_80000000 -> rsp_rdata=0xFFFFFFFFFFFFFF80.
//    Same access unsigned -> 0x80.
//  3 store half 0xBEEF @0x102 over bus_read=0x1111111111111111 -> one WR cycle,
//    bus_addr=0x100, bus_write=0x11111111BEEF1111, rsp at T+4.
//  4 store dword @0x108 with bus_exception=1 during WR -> rsp_fault=1, rsp_rdata=0.
//    Sub-dword store with exception in RD -> fault and bus_rw stays 0.
//  5 with LSU_MISALIGN_FAULT_EN: load word @0x102 -> rsp_fault=1 at T+1, no bus activity.
//    Without the macro: the access reads 0x100 lane 0.
//  6 rst_n low during WR of test 3 -> bus_rw=0 immediately, no rsp_valid.
//    After release, req_ready=1 and the next load succeeds.

Source files
------------

// File: rtl/lsu_bus_master.sv
// Load/store initiator for the 64-bit data bus: one access at a time, sub-dword loads extended,
// sub-dword stores done as read-modify-write. Optional macro: LSU_MISALIGN_FAULT_EN.
module lsu_bus_master #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        bus_rw,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_write,
    input  logic [63:0] bus_read,
    input  logic        bus_exception
);

    localparam int CNT_W = $clog2(RD_LATENCY + 2);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [63:0]       addr_p1, wdata_p1;
    logic [1:0]        size_p1;
    logic              store_p1, uns_p1;
    logic [2:0]        req_off;
    logic              misalign_fault;
    logic              req_ready_nx, rsp_valid_nx, rsp_fault_nx, bus_rw_nx;
    logic [63:0]       rsp_rdata_nx, bus_addr_nx, bus_write_nx;

    function automatic logic [2:0] low_mask(input logic [1:0] size);
        case (size)
            2'd0:    low_mask = 3'b000;
            2'd1:    low_mask = 3'b001;
            2'd2:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
            2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] rd, input logic [2:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [63:0] s;
        s = rd >> {off, 3'b000};
        case (size)
            2'd0:    load_extend = {{56{s[7]  & ~uns}}, s[7:0]};
            2'd1:    load_extend = {{48{s[15] & ~uns}}, s[15:0]};
            2'd2:    load_extend = {{32{s[31] & ~uns}}, s[31:0]};
            default: load_extend = s;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] rd, input logic [63:0] wd,
                                                input logic [2:0] off, input logic [1:0] size);
        logic [63:0] m;
        m = lane_mask(size);
        store_merge = (rd & ~(m << {off, 3'b000})) | ((wd & m) << {off, 3'b000});
    endfunction

`ifdef LSU_MISALIGN_FAULT_EN
    assign misalign_fault = |(req_addr[2:0] & low_mask(req_size));
    assign req_off        = req_addr[2:0];
`else
    // Misaligned offsets are snapped down to the natural boundary of the access size.
    assign misalign_fault = 1'b0;
    assign req_off        = req_addr[2:0] & ~low_mask(req_size);
`endif

    // Request capture (stage p1): data only, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            addr_p1  <= {req_addr[63:3], req_off};
            wdata_p1 <= req_wdata;
            size_p1  <= req_size;
            store_p1 <= req_store;
            uns_p1   <= req_unsigned;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rsp_valid_nx = 1'b0;
        rsp_fault_nx = 1'b0;
        rsp_rdata_nx = 64'd0;
        bus_rw_nx    = 1'b0;
        bus_addr_nx  = 64'd0;
        bus_write_nx = 64'd0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misalign_fault) begin
                        state_nx     = RESP;
                        rsp_valid_nx = 1'b1;
                        rsp_fault_nx = 1'b1;
                    end else if (req_store && req_size == 2'd3) begin
                        state_nx     = WR;
                        bus_rw_nx    = 1'b1;
                        bus_addr_nx  = {req_addr[63:3], 3'b000};
                        bus_write_nx = req_wdata;
                    end else begin
                        state_nx    = RD;
                        cnt_nx      = CNT_W'(RD_LATENCY);
                        bus_addr_nx = {req_addr[63:3], 3'b000};
                    end
                end
            end
            RD: begin
                bus_addr_nx = {addr_p1[63:3], 3'b000};
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else if (!store_p1) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_fault_nx = bus_exception;
                    rsp_rdata_nx = bus_exception ? 64'd0
                                 : load_extend(bus_read, addr_p1[2:0], size_p1, uns_p1);
                    bus_addr_nx  = 64'd0;
                end else if (bus_exception) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_fault_nx = 1'b1;
                    bus_addr_nx  = 64'd0;
                end else begin
                    state_nx     = WR;
                    bus_rw_nx    = 1'b1;
                    bus_write_nx = store_merge(bus_read, wdata_p1, addr_p1[2:0], size_p1);
                end
            end
            WR: begin
                state_nx     = RESP;
                rsp_valid_nx = 1'b1;
                rsp_fault_nx = bus_exception;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        req_ready_nx = (state_nx == IDLE);
    end

    // Control and output registers (stage p2): every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= 64'd0;
            bus_rw    <= 1'b0;
            bus_addr  <= 64'd0;
            bus_write <= 64'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ready <= req_ready_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_fault <= rsp_fault_nx;
            rsp_rdata <= rsp_rdata_nx;
            bus_rw    <= bus_rw_nx;
            bus_addr  <= bus_addr_nx;
            bus_write <= bus_write_nx;
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed vector table, reset-during-write sequence, and random
// accesses checked against a byte-level reference model.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_fault;
    logic [63:0] rsp_rdata;
    logic        bus_rw, bus_exception;
    logic [63:0] bus_addr, bus_write, bus_read;
    logic [63:0] rd_val;
    logic        exc_rd, exc_wr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_bus_master #(.RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_write(bus_write), .bus_read(bus_read), .bus_exception(bus_exception)
    );

    // Bus target: fixed read data, errors injected either on the read or on the write phase.
    assign bus_read      = rd_val;
    assign bus_exception = (exc_rd && !bus_rw && bus_addr != 64'd0) || (exc_wr && bus_rw);

    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdval;
        logic        erd;
        logic        ewr;
        logic [63:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_wr;
        logic [63:0] exp_bw;
    } vec_t;

    function automatic vec_t mkv(logic st, logic [1:0] sz, logic u, logic [63:0] a, logic [63:0] wd,
                                 logic [63:0] rv, logic er, logic ew, logic [63:0] xr, logic xf,
                                 int xl, int xw, logic [63:0] xb);
        vec_t v;
        v.store = st; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.rdval = rv;
        v.erd = er; v.ewr = ew; v.exp_rdata = xr; v.exp_fault = xf; v.exp_lat = xl;
        v.exp_wr = xw; v.exp_bw = xb;
        return v;
    endfunction

    // Reference model: byte-by-byte lane picking, latency from the number of bus phases.
    function automatic vec_t model(vec_t v);
        vec_t r;
        int nb, off;
        logic [63:0] val;
        r = v;
        nb = 1 << v.size;
        off = int'(v.addr[2:0]);
        r.exp_rdata = 64'd0; r.exp_bw = 64'd0; r.exp_wr = 0;
`ifdef LSU_MISALIGN_FAULT_EN
        if (off % nb != 0) begin
            r.exp_fault = 1'b1; r.exp_lat = 1;
            return r;
        end
`else
        off = off - (off % nb);
`endif
        if (!v.store) begin
            val = 64'd0;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = v.rdval[8*(off+i) +: 8];
            if (!v.uns && nb < 8 && val[8*nb-1])
                for (int i = nb; i < 8; i++) val[8*i +: 8] = 8'hFF;
            r.exp_fault = v.erd;
            r.exp_rdata = v.erd ? 64'd0 : val;
            r.exp_lat = 3;
        end else if (nb == 8) begin
            r.exp_fault = v.ewr; r.exp_lat = 2; r.exp_wr = 1; r.exp_bw = v.wdata;
        end else if (v.erd) begin
            r.exp_fault = 1'b1; r.exp_lat = 3;
        end else begin
            val = v.rdval;
            for (int i = 0; i < nb; i++) val[8*(off+i) +: 8] = v.wdata[8*i +: 8];
            r.exp_fault = v.ewr; r.exp_lat = 4; r.exp_wr = 1; r.exp_bw = val;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic run_and_check(input vec_t v, input bit hold_busy, input string tag);
        int   wr_cnt, lat;
        bit   done, seen, addr_ok;
        logic [63:0] bw, rdata;
        logic fault;
        @(negedge clk);
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        req_store = v.store; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        rd_val = v.rdval; exc_rd = v.erd; exc_wr = v.ewr;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold_busy) begin
            req_store = 1'b1; req_size = 2'd3; req_addr = 64'h800; req_wdata = 64'hA5A5;
        end else begin
            req_valid = 1'b0;
        end
        wr_cnt = 0; lat = 0; done = 0; seen = 0; addr_ok = 1; bw = 64'd0;
        rdata = 64'd0; fault = 1'b0;
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clk);
            if (bus_addr != 64'd0) begin
                seen = 1;
                if (bus_addr != {v.addr[63:3], 3'b000}) addr_ok = 0;
            end
            if (bus_rw) begin wr_cnt++; bw = bus_write; end
            if (rsp_valid) begin
                done = 1; lat = n; rdata = rsp_rdata; fault = rsp_fault; req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL %s.timeout: no rsp_valid within 20 cycles, want one at T+%0d", tag, v.exp_lat);
        end else begin
            chk({tag, ".lat"},   64'(lat), 64'(v.exp_lat));
            chk({tag, ".fault"}, 64'(fault), 64'(v.exp_fault));
            chk({tag, ".rdata"}, rdata, v.exp_rdata);
            chk({tag, ".wrcnt"}, 64'(wr_cnt), 64'(v.exp_wr));
            if (v.exp_wr != 0) chk({tag, ".bwrite"}, bw, v.exp_bw);
            chk({tag, ".busact"}, 64'(seen), 64'(!(v.exp_fault && v.exp_lat == 1)));
            chk({tag, ".baddr"}, 64'(addr_ok), 64'd1);
            @(negedge clk);
            chk({tag, ".pulse"}, 64'(rsp_valid), 64'd0);
            chk({tag, ".idle"},  64'(req_ready), 64'd1);
        end
        exc_rd = 1'b0; exc_wr = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        vec_t v;
        bit   got_wr;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0; rd_val = 64'd0; exc_rd = 1'b0; exc_wr = 1'b0;

        vecs[0]  = mkv(0, 3, 0, 64'h100, 64'h0, 64'h1122334455667788, 0, 0,
                       64'h1122334455667788, 0, 3, 0, 64'h0);
        vecs[1]  = mkv(0, 0, 0, 64'h103, 64'h0, 64'h0000000080000000, 0, 0,
                       64'hFFFFFFFFFFFFFF80, 0, 3, 0, 64'h0);
        vecs[2]  = mkv(0, 0, 1, 64'h103, 64'h0, 64'h0000000080000000, 0, 0,
                       64'h80, 0, 3, 0, 64'h0);
        vecs[3]  = mkv(1, 1, 0, 64'h102, 64'hBEEF, 64'h1111111111111111, 0, 0,
                       64'h0, 0, 4, 1, 64'h11111111BEEF1111);
        vecs[4]  = mkv(1, 3, 0, 64'h108, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 1,
                       64'h0, 1, 2, 1, 64'hDEADBEEFCAFEF00D);
        vecs[5]  = mkv(1, 2, 0, 64'h10C, 64'h12345678, 64'h5555555555555555, 1, 0,
                       64'h0, 1, 3, 0, 64'h0);
`ifdef LSU_MISALIGN_FAULT_EN
        vecs[6]  = mkv(0, 2, 0, 64'h102, 64'h0, 64'h8899AABBCCDDEEFF, 0, 0,
                       64'h0, 1, 1, 0, 64'h0);
`else
        vecs[6]  = mkv(0, 2, 0, 64'h102, 64'h0, 64'h8899AABBCCDDEEFF, 0, 0,
                       64'hFFFFFFFFCCDDEEFF, 0, 3, 0, 64'h0);
`endif
        vecs[7]  = mkv(0, 1, 1, 64'h106, 64'h0, 64'h8899AABBCCDDEEFF, 0, 0,
                       64'h8899, 0, 3, 0, 64'h0);
        vecs[8]  = mkv(0, 2, 0, 64'h104, 64'h0, 64'h8899AABBCCDDEEFF, 0, 0,
                       64'hFFFFFFFF8899AABB, 0, 3, 0, 64'h0);
        vecs[9]  = mkv(1, 0, 0, 64'h107, 64'hFFFFFFFFFFFFFF5A, 64'h0, 0, 0,
                       64'h0, 0, 4, 1, 64'h5A00000000000000);
        vecs[10] = mkv(0, 3, 0, 64'h200, 64'h0, 64'h123456789ABCDEF0, 1, 0,
                       64'h0, 1, 3, 0, 64'h0);

        repeat (3) @(negedge clk);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.rsp_rdata", rsp_rdata, 64'd0);
        chk("rst.rsp_fault", 64'(rsp_fault), 64'd0);
        chk("rst.bus_rw",    64'(bus_rw), 64'd0);
        chk("rst.bus_addr",  bus_addr, 64'd0);
        chk("rst.bus_write", bus_write, 64'd0);
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_and_check(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Reset asserted in the middle of the write phase of a half-word store.
        @(negedge clk);
        req_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 64'h102;
        req_wdata = 64'hBEEF; rd_val = 64'h1111111111111111; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got_wr = 0;
        for (int n = 0; n < 10 && !got_wr; n++) begin
            @(negedge clk);
            if (bus_rw) got_wr = 1;
        end
        chk("kill.reached_wr", 64'(got_wr), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("kill.bus_rw",    64'(bus_rw), 64'd0);
        chk("kill.bus_write", bus_write, 64'd0);
        chk("kill.bus_addr",  bus_addr, 64'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("kill.no_rsp", 64'(rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("kill.ready", 64'(req_ready), 64'd1);
        chk("kill.no_rsp_after", 64'(rsp_valid), 64'd0);
        run_and_check(vecs[0], 1'b0, "after_kill");

        for (int i = 0; i < 150; i++) begin
            v.store = 1'($urandom_range(0, 1));
            v.size  = 2'($urandom_range(0, 3));
            v.uns   = 1'($urandom_range(0, 1));
            v.addr  = {$urandom, $urandom} | 64'h100;
            v.wdata = {$urandom, $urandom};
            v.rdval = {$urandom, $urandom};
            v.erd   = ($urandom_range(0, 7) == 0);
            v.ewr   = ($urandom_range(0, 7) == 0);
            v = model(v);
            run_and_check(v, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
